// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store traffic.
// Only one transaction is outstanding at a time. Define MEM_ARB_ROUND_ROBIN_EN to get alternating priority.
module mem_port_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_fetch_o,
  output logic        stall_mem_o
);

  // state  | meaning
  // IDLE   | nothing outstanding, arbitrating between pending requests
  // WAIT_I | fetch accepted by memory, response pending
  // WAIT_D | data access accepted by memory, response pending
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   discard_q, discard_d;
  logic   last_grant_q, last_grant_d;  // 1 = data side was granted last
  logic   pick_data, pick_fetch, grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign pick_data = dm_req_i & (~if_req_i | ~last_grant_q);
`else
  assign pick_data = dm_req_i;
`endif
  assign pick_fetch = if_req_i & ~pick_data;
  assign grant      = (state_q == IDLE) & (pick_data | pick_fetch) & mem_gnt_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = pick_data ? WAIT_D : WAIT_I;
          last_grant_d = pick_data;
        end
      end
      WAIT_I: begin
        // A redirected fetch still owns the port until its response is swallowed.
        if (mem_rvalid_i) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else if (!if_req_i) begin
          discard_d = 1'b1;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if_ack_o    = 1'b0;
    if_rdata_o  = '0;
    dm_ack_o    = 1'b0;
    dm_rdata_o  = '0;
    // Outputs are gated by reset so they read zero the moment reset asserts.
    if (reset_i) begin
      case (state_q)
        IDLE: begin
          if (pick_data) begin
            mem_req_o   = 1'b1;
            mem_we_o    = dm_we_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
            mem_be_o    = dm_be_i;
          end else if (pick_fetch) begin
            mem_req_o  = 1'b1;
            mem_addr_o = if_addr_i;
            mem_be_o   = 4'hF;
          end
        end
        WAIT_I: begin
          if (mem_rvalid_i && if_req_i && !discard_q) begin
            if_ack_o   = 1'b1;
            if_rdata_o = mem_rdata_i;
          end
        end
        WAIT_D: begin
          if (mem_rvalid_i) begin
            dm_ack_o   = 1'b1;
            dm_rdata_o = mem_rdata_i;
          end
        end
        default: begin
          mem_req_o = 1'b0;
        end
      endcase
    end
    stall_fetch_o = reset_i & if_req_i & ~if_ack_o;
    stall_mem_o   = reset_i & dm_req_i & ~dm_ack_o;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model of the arbitration rules.
// Builds with or without MEM_ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [3:0]  dm_be_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_fetch_o;
  logic        stall_mem_o;

  mem_port_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_fetch_o(stall_fetch_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass = 0;

  // model: which side owns the port (0 none, 1 fetch, 2 data) and whether its response is dropped
  int m_side;
  bit m_disc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit m_last_d;
`endif

  // memory environment knobs
  int          gnt_pct, lat_min, lat_max, stray_pct;
  bit          mem_busy;
  int          mem_wait;
  bit          fixed_rd_en;
  logic [31:0] fixed_rd;

  logic        obs_mem_req, obs_mem_we, obs_if_ack, obs_dm_ack, obs_stall_fetch;
  logic [31:0] obs_mem_addr, obs_mem_wdata, obs_if_rdata, obs_dm_rdata;
  logic [3:0]  obs_mem_be;
  int          n_iack, n_dack;
  bit          gq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Winner among pending requests: fixed data-first, or the side not served last on a tie.
  function automatic int pick(input logic fi, input logic fd);
    int order[2];
    order[0] = 2;
    order[1] = 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (m_last_d) begin
      order[0] = 1;
      order[1] = 2;
    end
`endif
    for (int k = 0; k < 2; k++)
      if ((order[k] == 1 && fi) || (order[k] == 2 && fd)) return order[k];
    return 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_if_ack"}, if_ack_o, 0);
    check({tag, "_if_rdata"}, if_rdata_o, 0);
    check({tag, "_dm_ack"}, dm_ack_o, 0);
    check({tag, "_dm_rdata"}, dm_rdata_o, 0);
    check({tag, "_mem_req"}, mem_req_o, 0);
    check({tag, "_mem_we"}, mem_we_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_mem_be"}, mem_be_o, 0);
    check({tag, "_stall_fetch"}, stall_fetch_o, 0);
    check({tag, "_stall_mem"}, stall_mem_o, 0);
  endtask

  task automatic model_reset();
    m_side = 0;
    m_disc = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    m_last_d = 1;
`endif
    mem_busy = 0;
  endtask

  task automatic do_reset();
    reset_i = 0;
    if_req_i = 0;
    dm_req_i = 0;
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1;
  endtask

  // One clock cycle: called at negedge with requester inputs set.
  task automatic tick();
    int win;
    logic e_iack, e_dack;
    if (mem_busy) mem_rvalid_i = (mem_wait == 0);
    else mem_rvalid_i = ($urandom_range(99) < stray_pct);
    mem_rdata_i = fixed_rd_en ? fixed_rd : $urandom();
    mem_gnt_i = !mem_busy && ($urandom_range(99) < gnt_pct);
    #1;
    obs_mem_req = mem_req_o;  obs_mem_we = mem_we_o;  obs_mem_addr = mem_addr_o;
    obs_mem_wdata = mem_wdata_o;  obs_mem_be = mem_be_o;
    obs_if_ack = if_ack_o;  obs_if_rdata = if_rdata_o;
    obs_dm_ack = dm_ack_o;  obs_dm_rdata = dm_rdata_o;  obs_stall_fetch = stall_fetch_o;
    n_iack += int'(if_ack_o);
    n_dack += int'(dm_ack_o);

    assert (!(m_side == 2 && !dm_req_i)) else $error("dm_req_i dropped while a data access is outstanding");

    win = (m_side == 0) ? pick(if_req_i, dm_req_i) : 0;
    e_iack = (m_side == 1) && mem_rvalid_i && if_req_i && !m_disc;
    e_dack = (m_side == 2) && mem_rvalid_i;
    check("mem_req", mem_req_o, win != 0);
    if (win == 2) begin
      check("d_we", mem_we_o, dm_we_i);
      check("d_addr", mem_addr_o, dm_addr_i);
      check("d_wdata", mem_wdata_o, dm_wdata_i);
      check("d_be", mem_be_o, dm_be_i);
    end else if (win == 1) begin
      check("i_we", mem_we_o, 0);
      check("i_addr", mem_addr_o, if_addr_i);
      check("i_wdata", mem_wdata_o, 0);
      check("i_be", mem_be_o, 4'hF);
    end
    check("if_ack", if_ack_o, e_iack);
    check("if_rdata", if_rdata_o, e_iack ? mem_rdata_i : 32'h0);
    check("dm_ack", dm_ack_o, e_dack);
    check("dm_rdata", dm_rdata_o, e_dack ? mem_rdata_i : 32'h0);
    check("stall_fetch", stall_fetch_o, if_req_i && !e_iack);
    check("stall_mem", stall_mem_o, dm_req_i && !e_dack);

    if (mem_busy && mem_rvalid_i) mem_busy = 0;
    else if (mem_busy) mem_wait--;
    if (mem_req_o && mem_gnt_i) begin
      gq.push_back(mem_addr_o[31]);
      mem_busy = 1;
      mem_wait = $urandom_range(lat_max, lat_min);
    end

    if (m_side == 0) begin
      if (win != 0 && mem_gnt_i) begin
        m_side = win;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_last_d = (win == 2);
`endif
      end
    end else if (mem_rvalid_i) begin
      m_side = 0;
      m_disc = 0;
    end else if (m_side == 1 && !if_req_i) begin
      m_disc = 1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    bit idle = 0;
    if_req_i = 0;
    for (int c = 0; c < 30 && !idle; c++) begin
      if (m_side != 2) dm_req_i = 0;
      if (m_side == 0 && !mem_busy && !dm_req_i) idle = 1;
      else tick();
    end
    check("drain_idle", idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    gnt_pct = 100; lat_min = 0; lat_max = 0; stray_pct = 0;
    fixed_rd_en = 0; fixed_rd = '0; n_iack = 0; n_dack = 0;
    model_reset();
    if_req_i = 1; dm_req_i = 1; mem_rvalid_i = 1;
    @(negedge clk_i);
    #1 check_zero("rst");
    do_reset();

    // lone fetch
    fixed_rd_en = 1; fixed_rd = 32'hDEADBEEF;
    if_req_i = 1; if_addr_i = 32'h100;
    tick();
    check("lf_req", obs_mem_req, 1);
    check("lf_addr", obs_mem_addr, 32'h100);
    check("lf_stall_grant", obs_stall_fetch, 1);
    tick();
    check("lf_ack", obs_if_ack, 1);
    check("lf_rdata", obs_if_rdata, 32'hDEADBEEF);
    check("lf_stall_ack", obs_stall_fetch, 0);
    if_req_i = 0;
    tick();

    // store
    fixed_rd = 32'h0;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h2004; dm_wdata_i = 32'h12345678; dm_be_i = 4'b0011;
    tick();
    check("st_we", obs_mem_we, 1);
    check("st_addr", obs_mem_addr, 32'h2004);
    check("st_wdata", obs_mem_wdata, 32'h12345678);
    check("st_be", obs_mem_be, 4'b0011);
    tick();
    check("st_ack", obs_dm_ack, 1);
    check("st_rdata", obs_dm_rdata, 0);
    dm_req_i = 0; dm_we_i = 0;
    fixed_rd_en = 0;

    // redirect: fetch dropped while pending, response arrives two cycles later
    lat_min = 2; lat_max = 2; n_iack = 0;
    if_req_i = 1; if_addr_i = 32'h180;
    tick();
    check("rd_grant", obs_mem_req, 1);
    if_req_i = 0;
    tick();
    if_req_i = 1; if_addr_i = 32'h200;
    tick();
    tick();
    check("rd_no_ack", n_iack, 0);
    tick();
    check("rd_next_req", obs_mem_req, 1);
    check("rd_next_addr", obs_mem_addr, 32'h200);
    drain();

    // contention from reset: data raises first, fetch joins the next cycle
    do_reset();
    lat_min = 0; lat_max = 0; gq.delete(); n_iack = 0;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h8000_0000; dm_be_i = 4'hF; dm_wdata_i = 0;
    if_addr_i = 32'h400;
    for (int c = 0; c < 40 && gq.size() < 6; c++) begin
      tick();
      if_req_i = 1;
      if (obs_dm_ack) dm_addr_i += 4;
      if (obs_if_ack) if_addr_i += 4;
    end
    check("ct_count", gq.size(), 6);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] exp;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp = (k % 2 == 0) ? 32'd1 : 32'd0;
`else
      exp = 32'd1;
`endif
      check($sformatf("ct_grant%0d", k), (k < gq.size()) ? {31'b0, gq[k]} : 32'hFFFF_FFFF, exp);
    end
`ifndef MEM_ARB_ROUND_ROBIN_EN
    check("ct_no_if_ack", n_iack, 0);
`endif
    drain();

    // reset while a data access is outstanding
    lat_min = 3; lat_max = 3;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h3000;
    if_req_i = 1; if_addr_i = 32'h300;
    tick();
    check("rm_grant", obs_mem_addr, 32'h3000);
    tick();
    reset_i = 0; mem_rvalid_i = 1; mem_gnt_i = 1;
    #1 check_zero("rm");
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1; if_req_i = 0; mem_rvalid_i = 0;
    lat_min = 0; lat_max = 0; n_dack = 0;
    tick();
    check("rm_regrant", obs_mem_req, 1);
    check("rm_regrant_addr", obs_mem_addr, 32'h3000);
    tick();
    check("rm_ack", n_dack, 1);
    dm_req_i = 0;

    // random traffic
    gnt_pct = 60; lat_min = 0; lat_max = 3; stray_pct = 5;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (dm_req_i ? obs_dm_ack : ($urandom_range(3) == 0)) begin
        dm_req_i   = dm_req_i ? 1'($urandom_range(1)) : 1'b1;
        dm_we_i    = 1'($urandom_range(1));
        dm_addr_i  = $urandom();
        dm_wdata_i = $urandom();
        dm_be_i    = 4'($urandom_range(15));
      end
      if (if_req_i) begin
        if (obs_if_ack || $urandom_range(15) == 0) begin
          if_req_i  = 1'($urandom_range(1));
          if_addr_i = $urandom() & 32'hFFFF_FFFC;
        end
      end else if ($urandom_range(2) == 0) begin
        if_req_i  = 1;
        if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
